// File: rtl/pll_cal_sequencer_pkg.sv
// Shared types and constants for the PLL calibration sequencer.
// Holds the state encoding, the initial loop-filter setting and the charge-pump start point.
package pll_cal_pkg;

  typedef enum logic [2:0] {
    RST_HOLD,
    WAIT_LOCK,
    QUALIFY,
    FAIL_ATTEMPT,
    LOCKED,
    FAIL
  } state_t;

  localparam logic [2:0] LPF_INIT = 3'd2;

  // Starting charge-pump current grows with the feedback multiplication factor.
  function automatic logic [5:0] icp_init(input int multi_fac);
    if (multi_fac <= 8)       return 6'd16;
    else if (multi_fac <= 16) return 6'd24;
    else if (multi_fac <= 32) return 6'd32;
    else                      return 6'd40;
  endfunction

endpackage

// File: rtl/pll_cal_sequencer_if.sv
// Controller-to-PLL signal bundle: reset and loop-filter settings out, raw lock back.
interface pll_cal_if;

  logic       pll_lock;
  logic       o_pll_rst;
  logic [5:0] icpsel;
  logic [2:0] lpfres;

  modport master (input pll_lock, output o_pll_rst, output icpsel, output lpfres);
  modport slave  (output pll_lock, input o_pll_rst, input icpsel, input lpfres);

endinterface

// File: rtl/pll_cal_sequencer_sync.sv
// Two-flop synchronizer for a single asynchronous status bit, cleared by synchronous reset.
module cdc_sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_cal_sequencer.sv
// PLL reset/lock calibration controller: holds the PLL in reset, waits for and qualifies lock,
// sweeps charge-pump/loop-filter settings on failed attempts and restarts on loss of lock.
module pll_cal_sequencer
  import pll_cal_pkg::*;
#(
  parameter int CLK_PERIOD       = 20,
  parameter int MULTI_FAC        = 14,
  parameter int RST_CYCLES       = 64,
  parameter int LOCK_WAIT_CYCLES = 5000,
  parameter int STABLE_CYCLES    = 1024,
  parameter int LOL_FILTER       = 8,
  parameter int ICP_STEP         = 4,
  parameter int MAX_ATTEMPTS     = 16
) (
  input  logic                                init_clk,
  input  logic                                reset,
  pll_cal_if.master                           pll,
  output logic                                o_lock,
  output logic                                o_fail,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0]   o_attempts
);

  localparam int RST_W  = $clog2(RST_CYCLES + 1);
  localparam int WAIT_W = $clog2(LOCK_WAIT_CYCLES + 1);
  localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam int LOL_W  = $clog2(LOL_FILTER + 1);
  localparam int ATT_W  = $clog2(MAX_ATTEMPTS + 1);
  localparam logic [5:0] ICP_INIT = icp_init(MULTI_FAC);

  // CLK_PERIOD only documents the init_clk period; no logic depends on it.
  if (CLK_PERIOD <= 0) begin : g_clkPeriodUnset
  end

  state_t              r_state, w_stateNext;
  logic [RST_W-1:0]    r_rstCnt, w_rstCntNext, w_rstInc;
  logic [WAIT_W-1:0]   r_waitCnt, w_waitCntNext, w_waitInc;
  logic [STAB_W-1:0]   r_stableCnt, w_stableCntNext, w_stableInc;
  logic [LOL_W-1:0]    r_lolCnt, w_lolCntNext, w_lolInc;
  logic [ATT_W-1:0]    r_attempts, w_attemptsNext, w_attInc;
  logic [5:0]          r_icpsel, w_icpselNext;
  logic [2:0]          r_lpfres, w_lpfresNext;
  logic [6:0]          w_icpSum;
  logic                r_pllRst, r_lock, r_fail;
  logic                w_lockS;

  cdc_sync_2ff u_lockSync (
    .clk   (init_clk),
    .reset (reset),
    .i_d   (pll.pll_lock),
    .o_q   (w_lockS)
  );

  assign w_rstInc    = r_rstCnt + RST_W'(1);
  assign w_waitInc   = r_waitCnt + WAIT_W'(1);
  assign w_stableInc = r_stableCnt + STAB_W'(1);
  assign w_lolInc    = r_lolCnt + LOL_W'(1);
  assign w_attInc    = r_attempts + ATT_W'(1);
  assign w_icpSum    = {1'b0, r_icpsel} + 7'(ICP_STEP);

  // Each counter is cleared by the state that precedes its owner, so entry always starts at zero.
  always_comb begin
    w_stateNext     = r_state;
    w_rstCntNext    = r_rstCnt;
    w_waitCntNext   = r_waitCnt;
    w_stableCntNext = r_stableCnt;
    w_lolCntNext    = r_lolCnt;
    w_attemptsNext  = r_attempts;
    w_icpselNext    = r_icpsel;
    w_lpfresNext    = r_lpfres;
    case (r_state)
      RST_HOLD: begin
        w_waitCntNext = '0;
        if (w_rstInc == RST_W'(RST_CYCLES)) begin
          w_rstCntNext = '0;
          w_stateNext  = WAIT_LOCK;
        end else begin
          w_rstCntNext = w_rstInc;
        end
      end
      WAIT_LOCK: begin
        w_waitCntNext = w_waitInc;
        if (w_lockS) begin
          w_stableCntNext = '0;
          w_stateNext     = QUALIFY;
        end else if (w_waitInc == WAIT_W'(LOCK_WAIT_CYCLES)) begin
          w_stateNext = FAIL_ATTEMPT;
        end
      end
      QUALIFY: begin
        w_lolCntNext = '0;
        if (!w_lockS) begin
          w_stateNext = FAIL_ATTEMPT;
        end else begin
          w_stableCntNext = w_stableInc;
          if (w_stableInc == STAB_W'(STABLE_CYCLES)) w_stateNext = LOCKED;
        end
      end
      FAIL_ATTEMPT: begin
        w_attemptsNext = w_attInc;
        if (w_attInc == ATT_W'(MAX_ATTEMPTS)) begin
          w_stateNext = FAIL;
        end else begin
          w_stateNext = RST_HOLD;
          // Past the top of the charge-pump range, restart it and try the next filter resistor.
          if (w_icpSum > 7'd63) begin
            w_icpselNext = ICP_INIT;
            w_lpfresNext = r_lpfres + 3'd1;
          end else begin
            w_icpselNext = w_icpSum[5:0];
          end
        end
      end
      LOCKED: begin
        if (w_lockS) begin
          w_lolCntNext = '0;
        end else begin
          w_lolCntNext = w_lolInc;
          if (w_lolInc == LOL_W'(LOL_FILTER)) begin
            w_stateNext    = RST_HOLD;
            w_attemptsNext = '0;
          end
        end
      end
      FAIL:    w_stateNext = FAIL;
      default: w_stateNext = RST_HOLD;
    endcase
  end

  // Outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge init_clk) begin
    if (reset) begin
      r_state     <= RST_HOLD;
      r_rstCnt    <= '0;
      r_waitCnt   <= '0;
      r_stableCnt <= '0;
      r_lolCnt    <= '0;
      r_attempts  <= '0;
      r_icpsel    <= ICP_INIT;
      r_lpfres    <= LPF_INIT;
      r_pllRst    <= 1'b1;
      r_lock      <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_rstCnt    <= w_rstCntNext;
      r_waitCnt   <= w_waitCntNext;
      r_stableCnt <= w_stableCntNext;
      r_lolCnt    <= w_lolCntNext;
      r_attempts  <= w_attemptsNext;
      r_icpsel    <= w_icpselNext;
      r_lpfres    <= w_lpfresNext;
      r_pllRst    <= (w_stateNext == RST_HOLD) || (w_stateNext == FAIL);
      r_lock      <= (w_stateNext == LOCKED);
      r_fail      <= (w_stateNext == FAIL);
    end
  end

  assign pll.o_pll_rst = r_pllRst;
  assign pll.icpsel    = r_icpsel;
  assign pll.lpfres    = r_lpfres;
  assign o_lock        = r_lock;
  assign o_fail        = r_fail;
  assign o_attempts    = r_attempts;

endmodule

// File: tb/tb_pll_cal_sequencer.sv
// Bench for pll_cal_sequencer: two instances (main sweep and wrap sweep) checked every cycle
// against a phase-level model, plus directed scenarios with hand-computed expectations.
module tb_pll_cal_sequencer;

  localparam int RST_C  = 4;
  localparam int LW_C   = 20;
  localparam int STAB_C = 8;
  localparam int LOL_C  = 3;
  localparam int MF_C   = 14;
  localparam int STEP_A = 4;
  localparam int MAX_A  = 3;
  localparam int STEP_W = 16;
  localparam int MAX_W  = 8;
  localparam int ICP0   = 24;
  localparam int LPF0   = 2;

  localparam int PH_HOLD = 0, PH_WAIT = 1, PH_QUAL = 2, PH_RETRY = 3, PH_LOCKED = 4, PH_DEAD = 5;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rstA, rstW;
  logic       lockA, failA, lockW, failW;
  logic [1:0] attA;
  logic [3:0] attW;

  pll_cal_if pllA ();
  pll_cal_if pllW ();

  pll_cal_sequencer #(
    .CLK_PERIOD(20), .MULTI_FAC(MF_C), .RST_CYCLES(RST_C), .LOCK_WAIT_CYCLES(LW_C),
    .STABLE_CYCLES(STAB_C), .LOL_FILTER(LOL_C), .ICP_STEP(STEP_A), .MAX_ATTEMPTS(MAX_A)
  ) dutA (
    .init_clk(clk), .reset(rstA), .pll(pllA), .o_lock(lockA), .o_fail(failA), .o_attempts(attA)
  );

  pll_cal_sequencer #(
    .CLK_PERIOD(20), .MULTI_FAC(MF_C), .RST_CYCLES(RST_C), .LOCK_WAIT_CYCLES(LW_C),
    .STABLE_CYCLES(STAB_C), .LOL_FILTER(LOL_C), .ICP_STEP(STEP_W), .MAX_ATTEMPTS(MAX_W)
  ) dutW (
    .init_clk(clk), .reset(rstW), .pll(pllW), .o_lock(lockW), .o_fail(failW), .o_attempts(attW)
  );

  int nCompared   = 0;
  int nMismatched = 0;

  // Model state: phase, time spent in it, run lengths, and settings derived from change count.
  int mPhase[2], mElapsed[2], mGood[2], mBad[2], mFails[2], mChanges[2];
  bit mValid[2];
  bit mPipe[2][2];
  int pStep[2] = '{STEP_A, STEP_W};
  int pMax[2]  = '{MAX_A, MAX_W};

  function automatic int readOut(input int k, input int sel);
    if (k == 0) begin
      case (sel)
        0: return int'(pllA.o_pll_rst);
        1: return int'(pllA.icpsel);
        2: return int'(pllA.lpfres);
        3: return int'(lockA);
        4: return int'(failA);
        5: return int'(attA);
        default: return -1;
      endcase
    end else begin
      case (sel)
        0: return int'(pllW.o_pll_rst);
        1: return int'(pllW.icpsel);
        2: return int'(pllW.lpfres);
        3: return int'(lockW);
        4: return int'(failW);
        5: return int'(attW);
        default: return -1;
      endcase
    end
  endfunction

  function automatic int expOf(input int k, input int sel);
    int span;
    span = (63 - ICP0) / pStep[k] + 1;
    case (sel)
      0: return (mPhase[k] == PH_HOLD || mPhase[k] == PH_DEAD) ? 1 : 0;
      1: return ICP0 + pStep[k] * (mChanges[k] % span);
      2: return (LPF0 + mChanges[k] / span) % 8;
      3: return (mPhase[k] == PH_LOCKED) ? 1 : 0;
      4: return (mPhase[k] == PH_DEAD) ? 1 : 0;
      5: return mFails[k];
      default: return -1;
    endcase
  endfunction

  task automatic modelStep(input int k, input bit rstIn, input bit lockIn);
    bit seen;
    seen        = mPipe[k][1];
    mPipe[k][1] = mPipe[k][0];
    mPipe[k][0] = lockIn;
    if (rstIn) begin
      mValid[k] = 1'b1; mPhase[k] = PH_HOLD; mElapsed[k] = 0; mFails[k] = 0;
      mChanges[k] = 0; mGood[k] = 0; mBad[k] = 0; mPipe[k][0] = 1'b0; mPipe[k][1] = 1'b0;
      return;
    end
    if (!mValid[k]) return;
    case (mPhase[k])
      PH_HOLD: begin
        mElapsed[k]++;
        if (mElapsed[k] == RST_C) begin mPhase[k] = PH_WAIT; mElapsed[k] = 0; end
      end
      PH_WAIT: begin
        mElapsed[k]++;
        if (seen) begin mPhase[k] = PH_QUAL; mGood[k] = 0; end
        else if (mElapsed[k] == LW_C) mPhase[k] = PH_RETRY;
      end
      PH_QUAL: begin
        if (!seen) mPhase[k] = PH_RETRY;
        else begin
          mGood[k]++;
          if (mGood[k] == STAB_C) begin mPhase[k] = PH_LOCKED; mBad[k] = 0; end
        end
      end
      PH_RETRY: begin
        mFails[k]++;
        if (mFails[k] == pMax[k]) mPhase[k] = PH_DEAD;
        else begin mChanges[k]++; mPhase[k] = PH_HOLD; mElapsed[k] = 0; end
      end
      PH_LOCKED: begin
        mBad[k] = seen ? 0 : mBad[k] + 1;
        if (mBad[k] == LOL_C) begin mPhase[k] = PH_HOLD; mElapsed[k] = 0; mFails[k] = 0; end
      end
      default: ;
    endcase
  endtask

  initial begin
    forever begin
      @(posedge clk);
      modelStep(0, rstA, pllA.pll_lock);
      modelStep(1, rstW, pllW.pll_lock);
    end
  end

  task automatic compareInst(input int k);
    int act[6];
    int exp[6];
    bit bad;
    bad = 1'b0;
    for (int s = 0; s < 6; s++) begin
      act[s] = readOut(k, s);
      exp[s] = expOf(k, s);
      if (act[s] != exp[s]) bad = 1'b1;
    end
    nCompared++;
    if (bad) begin
      nMismatched++;
      $display("[TB] FAIL model_%0d t=%0t: got rst=%0d icp=%0d lpf=%0d lock=%0d fail=%0d att=%0d, want rst=%0d icp=%0d lpf=%0d lock=%0d fail=%0d att=%0d",
               k, $time, act[0], act[1], act[2], act[3], act[4], act[5],
               exp[0], exp[1], exp[2], exp[3], exp[4], exp[5]);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mValid[0]) compareInst(0);
      if (mValid[1]) compareInst(1);
    end
  end

  task automatic checkValue(input string name, input int got, input int want);
    nCompared++;
    if (got != want) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic checkOutput(input string name, input int k, input int sel, input int want);
    checkValue(name, readOut(k, sel), want);
  endtask

  task automatic waitFor(input string name, input int k, input int sel, input int want, input int budget);
    int n;
    n = 0;
    while (readOut(k, sel) != want && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkValue(name, readOut(k, sel), want);
  endtask

  task automatic applyStimulus(input int k, input bit lockVal, input int holdCycles);
    if (k == 0) pllA.pll_lock = lockVal;
    else        pllW.pll_lock = lockVal;
    repeat (holdCycles) @(negedge clk);
  endtask

  task automatic pulseResetA();
    pllA.pll_lock = 1'b0;
    rstA = 1'b1;
    repeat (2) @(negedge clk);
    rstA = 1'b0;
  endtask

  initial begin
    int n;
    rstA = 1'b1;
    rstW = 1'b1;
    pllA.pll_lock = 1'b0;
    pllW.pll_lock = 1'b0;
    repeat (3) @(negedge clk);

    for (int k = 0; k < 2; k++) begin
      checkOutput("reset_pllRst", k, 0, 1);
      checkOutput("reset_icpsel", k, 1, 24);
      checkOutput("reset_lpfres", k, 2, 2);
      checkOutput("reset_lock", k, 3, 0);
      checkOutput("reset_fail", k, 4, 0);
      checkOutput("reset_attempts", k, 5, 0);
    end

    // Wrap sweep: 24 -> 40 -> 56 -> 24 with the filter resistor stepping 2 -> 3.
    rstW = 1'b0;
    waitFor("wrap_att1", 1, 5, 1, 60);
    checkOutput("wrap_icp1", 1, 1, 40);
    checkOutput("wrap_lpf1", 1, 2, 2);
    waitFor("wrap_att2", 1, 5, 2, 60);
    checkOutput("wrap_icp2", 1, 1, 56);
    waitFor("wrap_att3", 1, 5, 3, 60);
    checkOutput("wrap_icp3", 1, 1, 24);
    checkOutput("wrap_lpf3", 1, 2, 3);
    waitFor("wrap_fail", 1, 4, 1, 400);
    checkOutput("wrap_failIcp", 1, 1, 40);
    checkOutput("wrap_failLpf", 1, 2, 4);
    checkOutput("wrap_failAtt", 1, 5, 8);
    checkOutput("wrap_failRst", 1, 0, 1);

    // Clean lock: rise 5 cycles after reset release, o_lock exactly 11 cycles later.
    rstA = 1'b0;
    waitFor("clean_rstFall", 0, 0, 0, 20);
    applyStimulus(0, 1'b0, 5);
    applyStimulus(0, 1'b1, 10);
    checkOutput("clean_lockAt10", 0, 3, 0);
    @(negedge clk);
    checkOutput("clean_lockAt11", 0, 3, 1);
    checkOutput("clean_icp", 0, 1, 24);
    checkOutput("clean_lpf", 0, 2, 2);
    checkOutput("clean_att", 0, 5, 0);

    // Three-cycle dropout during qualification costs one attempt.
    pulseResetA();
    waitFor("glitch_rstFall", 0, 0, 0, 20);
    applyStimulus(0, 1'b1, 3);
    applyStimulus(0, 1'b0, 3);
    pllA.pll_lock = 1'b1;
    waitFor("glitch_att1", 0, 5, 1, 20);
    checkOutput("glitch_icp", 0, 1, 28);
    checkOutput("glitch_noLock", 0, 3, 0);
    waitFor("glitch_relock", 0, 3, 1, 60);
    checkOutput("glitch_relockAtt", 0, 5, 1);

    // Loss of lock: two low cycles are filtered, three restart with settings kept.
    applyStimulus(0, 1'b0, 2);
    applyStimulus(0, 1'b1, 6);
    checkOutput("lol2_stillLocked", 0, 3, 1);
    applyStimulus(0, 1'b0, 3);
    pllA.pll_lock = 1'b1;
    @(negedge clk);
    checkOutput("lol3_beforeDrop", 0, 3, 1);
    @(negedge clk);
    checkOutput("lol3_lockDrop", 0, 3, 0);
    checkOutput("lol3_rst", 0, 0, 1);
    checkOutput("lol3_attCleared", 0, 5, 0);
    checkOutput("lol3_icpKept", 0, 1, 28);
    repeat (3) @(negedge clk);
    checkOutput("lol3_rstCycle4", 0, 0, 1);
    @(negedge clk);
    checkOutput("lol3_rstReleased", 0, 0, 0);

    // No lock ever: 24 -> 28 -> 32, 4-cycle reset pulses, then terminal failure.
    pulseResetA();
    waitFor("nolock_att1", 0, 5, 1, 40);
    checkOutput("nolock_icp1", 0, 1, 28);
    n = 0;
    while (readOut(0, 0) == 1 && n < 10) begin
      n++;
      @(negedge clk);
    end
    checkValue("nolock_rstPulse", n, 4);
    waitFor("nolock_att2", 0, 5, 2, 40);
    checkOutput("nolock_icp2", 0, 1, 32);
    waitFor("nolock_fail", 0, 4, 1, 40);
    checkOutput("nolock_failRst", 0, 0, 1);
    checkOutput("nolock_failIcp", 0, 1, 32);
    checkOutput("nolock_failAtt", 0, 5, 3);
    checkOutput("nolock_failLock", 0, 3, 0);

    // Reset in the middle of the second wait restores every reset value.
    pulseResetA();
    waitFor("midrst_att1", 0, 5, 1, 40);
    waitFor("midrst_inWait", 0, 0, 0, 10);
    repeat (3) @(negedge clk);
    rstA = 1'b1;
    @(negedge clk);
    checkOutput("midrst_rst", 0, 0, 1);
    checkOutput("midrst_icp", 0, 1, 24);
    checkOutput("midrst_lpf", 0, 2, 2);
    checkOutput("midrst_att", 0, 5, 0);
    checkOutput("midrst_fail", 0, 4, 0);
    rstA = 1'b0;
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
